// File: rtl/piso.sv
// piso: parallel-in serial-out serializer for the TRNG output path.
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out
// MSB first, one bit per en strobe, so a shift-in-at-bit-0 sipo on the same
// strobe rebuilds the word. Back-to-back words leave no gap on the link.
module piso #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             abort,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy,
    output logic [15:0]      words_sent
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;

    assign cnt_zero = (cnt == '0);

    // The only combinational input path: a word can be taken in IDLE, or in
    // the very cycle the final bit is strobed out so frames abut seamlessly.
    assign din_ready = (state == IDLE) |
                       ((state == SHIFT) & en & cnt_zero & ~abort);

    // Outputs decode straight from registers; shreg is zero whenever the
    // block is idle, so sout needs no extra gating.
    assign sout       = shreg[WIDTH-1];
    assign sout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign sout_last  = (state == SHIFT) & cnt_zero;

    // Frame FSM: load, shift on strobe, reload or retire after the last bit.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            words_sent <= '0;
        end else if (abort) begin
            // Abandon the frame outright; the partial word is never counted.
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        shreg <= din;
                        cnt   <= CNT_TOP;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        if (!cnt_zero) begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            cnt   <= cnt - 1'b1;
                        end else begin
                            words_sent <= words_sent + 16'd1;
                            if (din_valid) begin
                                shreg <= din;
                                cnt   <= CNT_TOP;
                            end else begin
                                shreg <= '0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    shreg <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso.sv
// tb_piso: scoreboard bench for the piso serializer with a sipo loopback.
`timescale 1ns/1ps
module tb_piso;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             clear_n = 1'b0;
    logic             abort = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             busy;
    logic [15:0]      words_sent;

    int n_checks = 0;
    int n_fails  = 0;

    // Scoreboard state: expected bits of the frame in flight, queued words.
    bit               exp_bits[$];
    logic [WIDTH-1:0] exp_words[$];
    logic [15:0]      mdl_words = '0;
    int               mdl_loads = 0;
    logic [WIDTH-1:0] chk_word = '0;
    bit               chk_pending = 1'b0;
    logic [WIDTH-1:0] sipo_q = '0;

    piso #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .abort      (abort),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .busy       (busy),
        .words_sent (words_sent)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void load(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) exp_bits.push_back(w[i]);
        exp_words.push_back(w);
        mdl_loads++;
    endfunction

    function automatic bit exp_ready();
        return (exp_bits.size() == 0) || (en && !abort && exp_bits.size() == 1);
    endfunction

    // Reference behaviour: consume/load expected bits on each clock edge.
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            exp_bits.delete();
            exp_words.delete();
            mdl_words   = '0;
            chk_pending = 1'b0;
        end else begin
            chk_pending = 1'b0;
            if (abort) begin
                exp_bits.delete();
                exp_words.delete();
            end else if (exp_bits.size() != 0) begin
                if (en) begin
                    void'(exp_bits.pop_front());
                    if (exp_bits.size() == 0) begin
                        mdl_words   = mdl_words + 16'd1;
                        chk_word    = exp_words.pop_front();
                        chk_pending = 1'b1;
                        if (din_valid) load(din);
                    end
                end
            end else if (din_valid) begin
                load(din);
            end
        end
    end

    // Downstream sipo: shift in at bit 0 on strobes qualified by sout_valid.
    always @(posedge clk) begin
        if (en && sout_valid) sipo_q <= {sipo_q[WIDTH-2:0], sout};
    end

    // Compare DUT outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin
        if (clear_n) begin
            check("din_ready", din_ready, exp_ready());
            check("sout_valid", sout_valid, exp_bits.size() != 0);
            check("busy", busy, exp_bits.size() != 0);
            check("words_sent", words_sent, mdl_words);
            if (exp_bits.size() != 0) begin
                check("sout", sout, exp_bits[0]);
                check("sout_last", sout_last, exp_bits.size() == 1);
            end else begin
                check("sout_idle", sout, 1'b0);
                check("sout_last_idle", sout_last, 1'b0);
            end
            if (chk_pending) check("sipo_word", sipo_q, chk_word);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] cap;
        logic [15:0]      cap16;
        int               nlast, nvalid, nready, loads0, c;

        // Reset state
        #3;
        check("rst_sout", sout, 1'b0);
        check("rst_sout_valid", sout_valid, 1'b0);
        check("rst_sout_last", sout_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_words", words_sent, 16'd0);
        repeat (2) @(posedge clk);
        #1 clear_n = 1'b1;
        #1 check("rst_ready", din_ready, 1'b1);

        // Single word A5 with en held high
        cyc(); din = 8'hA5; din_valid = 1'b1; en = 1'b1;
        cyc(); din_valid = 1'b0; din = '0;
        cap = '0; nlast = 0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            cap = {cap[WIDTH-2:0], sout};
            nlast += int'(sout_last);
            cyc();
        end
        check("a5_bits", cap, 8'hA5);
        check("a5_last_count", nlast, 1);
        check("a5_valid_after", sout_valid, 1'b0);
        check("a5_words", words_sent, 16'd1);
        check("a5_ready_after", din_ready, 1'b1);

        // Sparse strobe: en every third cycle
        cyc(); din = 8'h81; din_valid = 1'b1; en = 1'b0;
        cyc(); din_valid = 1'b0; din = '0;
        cap = '0; nvalid = 0;
        for (int i = 1; i <= 27; i++) begin
            en = (i % 3 == 0);
            @(negedge clk);
            if (sout_valid) nvalid++;
            if (en && sout_valid) cap = {cap[WIDTH-2:0], sout};
            cyc();
        end
        check("sparse_span", nvalid, 24);
        check("sparse_bits", cap, 8'h81);
        check("sparse_words", words_sent, 16'd2);

        // Back-to-back F0 then 0F
        cyc(); din = 8'hF0; din_valid = 1'b1; en = 1'b1;
        nvalid = 0; nready = 0; cap16 = '0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (din_ready) nready++;
            if (sout_valid) begin
                nvalid++;
                cap16 = {cap16[14:0], sout};
            end
            cyc();
            if (i == 0) din = 8'h0F;
            if (i == 8) begin
                din_valid = 1'b0;
                din = '0;
            end
        end
        check("b2b_valid_cycles", nvalid, 16);
        check("b2b_bits", cap16, 16'hF00F);
        check("b2b_ready_cycles", nready, 3);
        check("b2b_words", words_sent, 16'd4);

        // Abort after three bits, then a clean word
        cyc(); din = 8'hFF; din_valid = 1'b1; en = 1'b1;
        cyc(); din_valid = 1'b0; din = '0;
        repeat (3) cyc();
        abort = 1'b1;
        cyc(); abort = 1'b0;
        check("abort_valid", sout_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_words", words_sent, 16'd4);
        din = 8'h3C; din_valid = 1'b1;
        cyc(); din_valid = 1'b0; din = '0;
        cap = '0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            cap = {cap[WIDTH-2:0], sout};
            cyc();
        end
        check("post_abort_bits", cap, 8'h3C);
        check("post_abort_words", words_sent, 16'd5);

        // Asynchronous reset during bit 4
        cyc(); din = 8'h55; din_valid = 1'b1; en = 1'b1;
        cyc(); din_valid = 1'b0; din = '0;
        repeat (3) cyc();
        #2 clear_n = 1'b0;
        #1;
        check("arst_sout", sout, 1'b0);
        check("arst_valid", sout_valid, 1'b0);
        check("arst_last", sout_last, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_words", words_sent, 16'd0);
        cyc(); cyc();
        clear_n = 1'b1;

        // Loopback: 100 random words with random strobe and source gaps
        loads0 = mdl_loads;
        c = 0;
        while ((mdl_loads - loads0) < 100 && c < 6000) begin
            din = WIDTH'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 3) != 0);
            cyc();
            c++;
        end
        din_valid = 1'b0; din = '0; en = 1'b1;
        check("loop_loads", mdl_loads - loads0, 100);
        c = 0;
        while (exp_bits.size() != 0 && c < 100) begin
            cyc();
            c++;
        end
        check("loop_drained", sout_valid, 1'b0);
        check("loop_words", words_sent, 16'd100);

        // Counter wrap from 65535
        cyc();
        force dut.words_sent = 16'hFFFF;
        mdl_words = 16'hFFFF;
        #1 release dut.words_sent;
        #1 check("wrap_preset", words_sent, 16'hFFFF);
        cyc(); din = 8'h96; din_valid = 1'b1; en = 1'b1;
        cyc(); din_valid = 1'b0; din = '0;
        repeat (WIDTH) cyc();
        check("wrap_words", words_sent, 16'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
